// File: rtl/uart_rx_framer.sv
// UART receive framer: Rx synchroniser, start detect, mid-bit 3-sample vote,
// 7/8 data bits, optional parity, 1/2 stop bits, error strobes.
module uart_rx_framer #(
  parameter int unsigned MIN_DIV     = 4,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic        MCLK,
  input  logic        reset,
  input  logic        en,
  input  logic        rx,
  input  logic [15:0] br_div,
  input  logic        pen,
  input  logic        par,
  input  logic        msb,
  input  logic        bit7,
  input  logic        spb,
  input  logic        rxifg,
  output logic [7:0]  rx_data,
  output logic        rx_valid,
  output logic        stt,
  output logic        pe,
  output logic        fe,
  output logic        oe,
  output logic        busy
);

  localparam int unsigned SS    = (SYNC_STAGES < 2) ? 2 : SYNC_STAGES;
  localparam logic [15:0] MIN_D = 16'(MIN_DIV);

  typedef enum logic [2:0] {
    S_IDLE, S_START, S_DATA, S_PAR,
    S_STOP1, S_STOP2, S_RECOV
  } state_t;

  typedef struct packed {
    logic        pen;
    logic        par;
    logic        msb;
    logic        bit7;
    logic        spb;
    logic [15:0] d;
  } cfg_t;

  state_t      r_state, w_state_n;
  cfg_t        r_cfg, w_cfg_n;
  logic [SS-1:0] r_sync;
  logic [15:0] r_cnt, w_cnt_n;
  logic [2:0]  r_idx, w_idx_n;
  logic [7:0]  r_sh, w_sh_n;
  logic [7:0]  r_rx_data, w_rx_data_n;
  logic        r_s0, w_s0_n;
  logic        r_s1, w_s1_n;
  logic        r_xor, w_xor_n;
  logic        r_perr, w_perr_n;
  logic        r_ferr, w_ferr_n;
  logic        r_valid, w_valid_n;
  logic        r_stt, w_stt_n;
  logic        r_pe, w_pe_n;
  logic        r_fe, w_fe_n;
  logic        r_oe, w_oe_n;

  logic        w_rs;
  logic [15:0] w_div;
  logic [15:0] w_h;
  logic        w_last;
  logic        w_eval;
  logic        w_maj;
  logic        w_done;
  logic [2:0]  w_nm1;
  logic [2:0]  w_pos;

  assign w_rs   = r_sync[SS-1];
  assign w_div  = (br_div < MIN_D) ? MIN_D : br_div;
  assign w_h    = {1'b0, r_cfg.d[15:1]};
  assign w_last = (r_cnt == r_cfg.d - 16'd1);
  assign w_eval = (r_cnt == w_h + 16'd1);
  assign w_maj  = (r_s0 & r_s1) | (r_s0 & w_rs) | (r_s1 & w_rs);
  assign w_nm1  = r_cfg.bit7 ? 3'd6 : 3'd7;
  assign w_pos  = r_cfg.msb ? (w_nm1 - r_idx) : r_idx;

  assign rx_data  = r_rx_data;
  assign rx_valid = r_valid;
  assign stt      = r_stt;
  assign pe       = r_pe;
  assign fe       = r_fe;
  assign oe       = r_oe;
  assign busy     = (r_state != S_IDLE);

  always_comb begin
    w_state_n   = r_state;
    w_cfg_n     = r_cfg;
    w_cnt_n     = w_last ? 16'd0 : r_cnt + 16'd1;
    w_idx_n     = r_idx;
    w_sh_n      = r_sh;
    w_rx_data_n = r_rx_data;
    w_s0_n      = r_s0;
    w_s1_n      = r_s1;
    w_xor_n     = r_xor;
    w_perr_n    = r_perr;
    w_ferr_n    = r_ferr;
    w_valid_n   = 1'b0;
    w_stt_n     = 1'b0;
    w_pe_n      = 1'b0;
    w_fe_n      = 1'b0;
    w_oe_n      = 1'b0;
    w_done      = 1'b0;

    if (r_state != S_IDLE) begin
      if (r_cnt == w_h - 16'd1) w_s0_n = w_rs;
      if (r_cnt == w_h) w_s1_n = w_rs;
    end

    unique case (r_state)
      S_IDLE: begin
        w_cnt_n = 16'd0;
        if (!w_rs) begin
          // the detecting cycle is bit count 0
          w_state_n    = S_START;
          w_cnt_n      = 16'd1;
          w_cfg_n.pen  = pen;
          w_cfg_n.par  = par;
          w_cfg_n.msb  = msb;
          w_cfg_n.bit7 = bit7;
          w_cfg_n.spb  = spb;
          w_cfg_n.d    = w_div;
          w_idx_n      = 3'd0;
          w_sh_n       = 8'h00;
          w_xor_n      = 1'b0;
          w_perr_n     = 1'b0;
          w_ferr_n     = 1'b0;
        end
      end
      S_START: begin
        if (w_eval && w_maj) begin
          w_state_n = S_IDLE;
          w_cnt_n   = 16'd0;
        end else begin
          if (w_eval) w_stt_n = 1'b1;
          if (w_last) begin
            w_state_n = S_DATA;
            w_idx_n   = 3'd0;
          end
        end
      end
      S_DATA: begin
        if (w_eval) begin
          w_sh_n[w_pos] = w_maj;
          w_xor_n       = r_xor ^ w_maj;
        end
        if (w_last) begin
          w_idx_n = r_idx + 3'd1;
          if (r_idx == w_nm1)
            w_state_n = r_cfg.pen ? S_PAR : S_STOP1;
        end
      end
      S_PAR: begin
        if (w_eval && ((r_xor ^ w_maj) != ~r_cfg.par))
          w_perr_n = 1'b1;
        if (w_last) w_state_n = S_STOP1;
      end
      S_STOP1: begin
        if (w_eval) begin
          if (r_cfg.spb) w_ferr_n = r_ferr | ~w_maj;
          else           w_done   = 1'b1;
        end
        if (w_last && r_cfg.spb) w_state_n = S_STOP2;
      end
      S_STOP2: begin
        if (w_eval) w_done = 1'b1;
      end
      S_RECOV: begin
        w_cnt_n = 16'd0;
        if (w_rs) w_state_n = S_IDLE;
      end
      default: begin
        w_state_n = S_IDLE;
        w_cnt_n   = 16'd0;
      end
    endcase

    if (w_done) begin
      // a low final stop means the line may stay low: wait for idle
      w_rx_data_n = r_sh;
      w_valid_n   = 1'b1;
      w_pe_n      = r_perr;
      w_fe_n      = r_ferr | ~w_maj;
      w_oe_n      = rxifg;
      w_state_n   = w_maj ? S_IDLE : S_RECOV;
      w_perr_n    = 1'b0;
      w_ferr_n    = 1'b0;
      w_cnt_n     = 16'd0;
    end

    if (!en) begin
      w_state_n   = S_IDLE;
      w_cfg_n     = '0;
      w_cnt_n     = 16'd0;
      w_idx_n     = 3'd0;
      w_sh_n      = 8'h00;
      w_rx_data_n = 8'h00;
      w_s0_n      = 1'b0;
      w_s1_n      = 1'b0;
      w_xor_n     = 1'b0;
      w_perr_n    = 1'b0;
      w_ferr_n    = 1'b0;
      w_valid_n   = 1'b0;
      w_stt_n     = 1'b0;
      w_pe_n      = 1'b0;
      w_fe_n      = 1'b0;
      w_oe_n      = 1'b0;
    end
  end

  always_ff @(posedge MCLK or posedge reset) begin
    if (reset) begin
      r_sync    <= '1;
      r_state   <= S_IDLE;
      r_cfg     <= '0;
      r_cnt     <= 16'd0;
      r_idx     <= 3'd0;
      r_sh      <= 8'h00;
      r_rx_data <= 8'h00;
      r_s0      <= 1'b0;
      r_s1      <= 1'b0;
      r_xor     <= 1'b0;
      r_perr    <= 1'b0;
      r_ferr    <= 1'b0;
      r_valid   <= 1'b0;
      r_stt     <= 1'b0;
      r_pe      <= 1'b0;
      r_fe      <= 1'b0;
      r_oe      <= 1'b0;
    end else begin
      r_sync    <= {r_sync[SS-2:0], rx};
      r_state   <= w_state_n;
      r_cfg     <= w_cfg_n;
      r_cnt     <= w_cnt_n;
      r_idx     <= w_idx_n;
      r_sh      <= w_sh_n;
      r_rx_data <= w_rx_data_n;
      r_s0      <= w_s0_n;
      r_s1      <= w_s1_n;
      r_xor     <= w_xor_n;
      r_perr    <= w_perr_n;
      r_ferr    <= w_ferr_n;
      r_valid   <= w_valid_n;
      r_stt     <= w_stt_n;
      r_pe      <= w_pe_n;
      r_fe      <= w_fe_n;
      r_oe      <= w_oe_n;
    end
  end

endmodule

// File: tb/tb_uart_rx_framer.sv
// Directed bench for uart_rx_framer: frames, parity, glitch, framing
// error with held-low line, 7-bit MSB-first two-stop, overrun, reset, enable.
module tb_uart_rx_framer;

  localparam int BIT = 16;

  logic        MCLK = 1'b0;
  logic        reset;
  logic        en;
  logic        rx;
  logic [15:0] br_div;
  logic        pen;
  logic        par;
  logic        msb;
  logic        bit7;
  logic        spb;
  logic        rxifg;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        stt;
  logic        pe;
  logic        fe;
  logic        oe;
  logic        busy;

  int n_cmp = 0;
  int n_err = 0;

  int cyc = 0;
  int n_stt = 0;
  int n_val = 0;
  int n_dbl = 0;
  int n_coin = 0;
  int stt_cyc = 0;
  logic [7:0] c_data = 8'h00;
  logic c_pe = 1'b0;
  logic c_fe = 1'b0;
  logic c_oe = 1'b0;
  logic c_busy = 1'b0;
  logic p_stt = 1'b0;
  logic p_val = 1'b0;

  int b_s;
  int b_v;
  int t0;
  int lat;
  logic [6:0] v7;

  uart_rx_framer #(.MIN_DIV(4), .SYNC_STAGES(2)) dut (
    .MCLK(MCLK), .reset(reset), .en(en), .rx(rx),
    .br_div(br_div), .pen(pen), .par(par), .msb(msb),
    .bit7(bit7), .spb(spb), .rxifg(rxifg),
    .rx_data(rx_data), .rx_valid(rx_valid), .stt(stt),
    .pe(pe), .fe(fe), .oe(oe), .busy(busy)
  );

  always #5 MCLK = ~MCLK;

  always @(negedge MCLK) begin
    cyc++;
    if (stt) begin
      n_stt++;
      stt_cyc = cyc;
    end
    if (rx_valid) begin
      n_val++;
      c_data = rx_data;
      c_pe = pe;
      c_fe = fe;
      c_oe = oe;
      c_busy = busy;
    end
    if ((stt && p_stt) || (rx_valid && p_val)) n_dbl++;
    if (stt && rx_valid) n_coin++;
    p_stt = stt;
    p_val = rx_valid;
  end

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic tx_bit(input logic v);
    rx = v;
    repeat (BIT) @(negedge MCLK);
  endtask

  task automatic tx_frame(input logic [7:0] d, input int nb,
                          input logic msbf, input logic up,
                          input logic pb, input int ns,
                          input logic sv);
    tx_bit(1'b0);
    for (int i = 0; i < nb; i++)
      tx_bit(msbf ? d[nb-1-i] : d[i]);
    if (up) tx_bit(pb);
    for (int s = 0; s < ns; s++) tx_bit(sv);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: sim time limit reached");
    $fatal(1);
  end

  initial begin
    reset = 1'b1; en = 1'b1; rx = 1'b1; br_div = 16'd16;
    pen = 1'b0; par = 1'b0; msb = 1'b0; bit7 = 1'b0;
    spb = 1'b0; rxifg = 1'b0;
    repeat (3) @(negedge MCLK);
    #1;
    chk("rst_data", rx_data, 8'h00);
    chk("rst_busy", busy, 1'b0);
    chk("rst_strb", {rx_valid, stt, pe, fe, oe}, 5'd0);
    @(negedge MCLK);
    reset = 1'b0;
    repeat (4) @(negedge MCLK);

    // 8N1 0x55
    b_s = n_stt; b_v = n_val; t0 = cyc;
    tx_frame(8'h55, 8, 1'b0, 1'b0, 1'b0, 1, 1'b1);
    rx = 1'b1;
    repeat (8) @(negedge MCLK);
    #1;
    lat = stt_cyc - t0;
    chk("t1_stt_n", n_stt - b_s, 1);
    chk("t1_stt_lat", (lat >= 8 && lat <= 16), 1);
    chk("t1_val_n", n_val - b_v, 1);
    chk("t1_data", c_data, 8'h55);
    chk("t1_err", {c_pe, c_fe, c_oe}, 3'd0);
    chk("t1_busy_at_val", c_busy, 1'b0);

    // 8E1 0xA3, bad then good parity
    pen = 1'b1; par = 1'b1;
    b_v = n_val;
    tx_frame(8'hA3, 8, 1'b0, 1'b1, 1'b1, 1, 1'b1);
    repeat (8) @(negedge MCLK);
    #1;
    chk("t2a_val_n", n_val - b_v, 1);
    chk("t2a_data", c_data, 8'hA3);
    chk("t2a_pe", c_pe, 1'b1);
    chk("t2a_fe", c_fe, 1'b0);
    b_v = n_val;
    tx_frame(8'hA3, 8, 1'b0, 1'b1, 1'b0, 1, 1'b1);
    repeat (8) @(negedge MCLK);
    #1;
    chk("t2b_val_n", n_val - b_v, 1);
    chk("t2b_data", c_data, 8'hA3);
    chk("t2b_pe", c_pe, 1'b0);
    pen = 1'b0; par = 1'b0;

    // 3-cycle glitch
    b_s = n_stt; b_v = n_val;
    rx = 1'b0;
    repeat (3) @(negedge MCLK);
    rx = 1'b1;
    repeat (6) @(negedge MCLK);
    #1;
    chk("t3_busy_mid", busy, 1'b1);
    repeat (8) @(negedge MCLK);
    #1;
    chk("t3_busy_end", busy, 1'b0);
    chk("t3_stt_n", n_stt - b_s, 0);
    chk("t3_val_n", n_val - b_v, 0);

    // framing error, line held low
    b_s = n_stt; b_v = n_val;
    tx_frame(8'h3C, 8, 1'b0, 1'b0, 1'b0, 1, 1'b0);
    repeat (64) @(negedge MCLK);
    #1;
    chk("t4_busy_low", busy, 1'b1);
    chk("t4_val_n", n_val - b_v, 1);
    chk("t4_data", c_data, 8'h3C);
    chk("t4_fe", c_fe, 1'b1);
    chk("t4_pe", c_pe, 1'b0);
    rx = 1'b1;
    repeat (6) @(negedge MCLK);
    #1;
    chk("t4_busy_high", busy, 1'b0);
    chk("t4_stt_n", n_stt - b_s, 1);
    chk("t4_val_n2", n_val - b_v, 1);

    // 7-bit, MSB first, two stop bits
    bit7 = 1'b1; msb = 1'b1; spb = 1'b1;
    b_v = n_val;
    v7 = 7'h2D;
    tx_bit(1'b0);
    for (int i = 0; i < 7; i++) tx_bit(v7[6-i]);
    tx_bit(1'b1);
    #1;
    chk("t5_no_val_stop1", n_val - b_v, 0);
    tx_bit(1'b1);
    repeat (4) @(negedge MCLK);
    #1;
    chk("t5_val_n", n_val - b_v, 1);
    chk("t5_data", c_data, 8'h2D);
    chk("t5_err", {c_pe, c_fe, c_oe}, 3'd0);
    bit7 = 1'b0; msb = 1'b0; spb = 1'b0;

    // overrun
    rxifg = 1'b1;
    b_v = n_val;
    tx_frame(8'h81, 8, 1'b0, 1'b0, 1'b0, 1, 1'b1);
    repeat (8) @(negedge MCLK);
    #1;
    rxifg = 1'b0;
    chk("t6_val_n", n_val - b_v, 1);
    chk("t6_data", c_data, 8'h81);
    chk("t6_oe", c_oe, 1'b1);

    // async reset at data bit 4
    b_v = n_val;
    tx_bit(1'b0);
    for (int i = 0; i < 4; i++) tx_bit(1'b1);
    repeat (8) @(negedge MCLK);
    reset = 1'b1;
    #1;
    chk("t7_rst_data", rx_data, 8'h00);
    chk("t7_rst_busy", busy, 1'b0);
    chk("t7_rst_strb", {rx_valid, stt, pe, fe, oe}, 5'd0);
    repeat (2) @(negedge MCLK);
    rx = 1'b1;
    reset = 1'b0;
    repeat (4) @(negedge MCLK);
    chk("t7_no_partial", n_val - b_v, 0);
    b_v = n_val;
    tx_frame(8'h12, 8, 1'b0, 1'b0, 1'b0, 1, 1'b1);
    repeat (8) @(negedge MCLK);
    #1;
    chk("t7_val_n", n_val - b_v, 1);
    chk("t7_data", c_data, 8'h12);
    chk("t7_err", {c_pe, c_fe, c_oe}, 3'd0);

    // en dropped mid-frame
    b_v = n_val;
    tx_bit(1'b0);
    tx_bit(1'b1);
    en = 1'b0;
    @(negedge MCLK);
    #1;
    chk("t8_en_busy", busy, 1'b0);
    chk("t8_en_data", rx_data, 8'h00);
    rx = 1'b1;
    en = 1'b1;
    repeat (40) @(negedge MCLK);
    #1;
    chk("t8_val_n", n_val - b_v, 0);
    chk("t8_busy_end", busy, 1'b0);

    chk("strobe_dbl", n_dbl, 0);
    chk("stt_val_coin", n_coin, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/uart_rx_framer.md
Name: uart_rx_framer

Overview:
- Asynchronous serial receive front end for the eUSCI_A UART path. Sits directly upstream of the eUSCI_A register file.
- Synchronises the Rx pin and detects the start bit. Times each bit with an internal bit-period counter and takes a 3-sample majority vote at mid-bit.
- Deframes 7/8 data bits, optional parity and 1/2 stop bits.
- Outputs the received byte, a completion strobe and error strobes (PE/FE/OE/STT), which feed RXBUF, UCAxSTATW and UCAxIFG.

Parameters:
- MIN_DIV, 4, floor applied to br_div; any br_div below this is treated as MIN_DIV.
- SYNC_STAGES, 2, number of flops in the Rx input synchroniser (minimum 2).

Ports:
- MCLK  input  1  system clock; all state on rising edge.
- reset  input  1  asynchronous, active-high; clears all state immediately.
- en  input  1  synchronous enable (driven by ~UCSWRST); en=0 forces IDLE and clears outputs on the next edge.
- rx  input  1  serial line (idle high), asynchronous to MCLK.
- br_div  input  16  MCLK cycles per bit.
- pen  input  1  parity enable.
- par  input  1  parity sense: 0 = odd, 1 = even.
- msb  input  1  1 = MSB first.
- bit7  input  1  1 = 7 data bits.
- spb  input  1  1 = two stop bits.
- rxifg  input  1  receive buffer still unread; used for overrun detection.
- rx_data  output  8  last received character; bit7 = 0 in 7-bit mode.
- rx_valid  output  1  1-cycle strobe: frame complete, rx_data updated.
- stt  output  1  1-cycle strobe: valid start bit confirmed.
- pe  output  1  1-cycle strobe coincident with rx_valid: parity error.
- fe  output  1  1-cycle strobe coincident with rx_valid: stop bit sampled low.
- oe  output  1  1-cycle strobe coincident with rx_valid: rxifg was high at completion.
- busy  output  1  high in any state other than IDLE.

Behaviour:
- Reset values: rx_data=0x00; rx_valid, stt, pe, fe, oe, busy = 0; state=IDLE; synchroniser flops = 1.
- Synchroniser output rs = rx delayed by SYNC_STAGES cycles. All decisions use rs.
- Definitions:
  - D = max(br_div, MIN_DIV).
  - H = D>>1.
  - cnt is a 16-bit counter that runs 0..D-1 within each bit, then wraps to 0 and advances the bit.
  - Samples are taken at cnt = H-1, H, H+1. The bit value is the majority of these three.
  - Evaluation occurs in the cycle with cnt = H+1. Registered results appear on the following edge.
- Config latch: on start detection, pen, par, msb, bit7, spb and D are latched. Changes mid-frame have no effect until the next frame.
- IDLE: when rs=0 is seen, go to START with cnt=0 (that cycle counts as cnt 0).
- START:
  - Majority=1 (glitch): return to IDLE at evaluation. No stt.
  - Majority=0: stt pulses for 1 cycle; continue counting to D-1, then enter DATA with bit index 0.
- DATA: N = bit7 ? 7 : 8 bits.
  - LSB first: bit i goes to shift position i.
  - MSB first: the first bit goes to position N-1.
  - After bit N-1 wraps, go to PARITY if pen, else STOP1.
- PARITY: XOR of the data bits and the parity bit must equal ~par (even ⇒ 0, odd ⇒ 1); mismatch sets an internal perr flag.
- STOP1: majority=0 sets an internal ferr flag.
  - spb=0: complete at evaluation.
  - spb=1: wrap into STOP2.
- STOP2: same check as STOP1; complete at evaluation.
- Completion, on the next edge:
  - rx_data loaded; rx_valid=1.
  - pe=perr, fe=ferr, oe=rxifg sampled in the evaluation cycle.
  - Next state: IDLE if the final stop majority was 1, else RECOVER.
  - perr and ferr clear.
- RECOVER: wait for rs=1, then go to IDLE. A line held low never produces a second frame.
- busy is high in START through RECOVER.
- Async reset mid-frame: all outputs clear immediately. No rx_valid is produced for the partial frame.
- en=0 mid-frame: same as reset, but takes effect at the next edge.
- Strobes never last more than one cycle. stt and rx_valid never coincide for the same frame.

Test Plan:
- br_div=16, 8N1 LSB-first, byte 0x55 → stt once ~8 cycles after the falling edge; rx_valid once; rx_data=0x55; pe=fe=oe=0; busy falls with rx_valid.
- 8E1 (pen=1, par=1), byte 0xA3 sent with parity bit 1 → rx_data=0xA3, pe=1 with rx_valid; same frame with parity bit 0 → pe=0.
- rx low for 3 cycles while idle, br_div=16 → no stt, no rx_valid; busy returns to 0 at the evaluation cycle.
- 8N1 byte 0x3C with stop bit driven 0, then rx held low for 64 cycles, then high → rx_data=0x3C, fe=1; only one rx_valid, one stt; state returns to IDLE only after the line goes high.
- bit7=1, msb=1, spb=1, value 0x2D (serial 0101101) → rx_data=0x2D; rx_valid occurs after the second stop bit.
- rxifg held 1 during a 0x81 frame → oe=1 with rx_valid.
- Assert reset at data bit 4 → all outputs 0 the same cycle; next full frame 0x12 is received correctly.
